// File: rtl/axi_chk_pkg.sv
// Shared state encoding and AXI field constants for the write/read-back checker.
package axi_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RD,
    ST_RR,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_8B    = 3'd3;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/axi_wr_rd_checker_if.sv
// Single-beat AXI4 subset used by the checker; suffixes are from the master's view.
interface axi_wr_rd_checker_if
  import axi_chk_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 5,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);

  logic                  aw_valid_o;
  logic                  aw_ready_i;
  logic [ADDR_WIDTH-1:0] aw_addr_o;
  logic [ID_WIDTH-1:0]   aw_id_o;
  logic [7:0]            aw_len_o;
  logic [2:0]            aw_size_o;
  logic [1:0]            aw_burst_o;

  logic                  w_valid_o;
  logic                  w_ready_i;
  logic [DATA_WIDTH-1:0] w_data_o;
  logic [7:0]            w_strb_o;
  logic                  w_last_o;

  logic                  b_valid_i;
  logic                  b_ready_o;
  resp_t                 b_resp_i;

  logic                  ar_valid_o;
  logic                  ar_ready_i;
  logic [ADDR_WIDTH-1:0] ar_addr_o;
  logic [ID_WIDTH-1:0]   ar_id_o;
  logic [7:0]            ar_len_o;
  logic [2:0]            ar_size_o;
  logic [1:0]            ar_burst_o;

  logic                  r_valid_i;
  logic                  r_ready_o;
  logic [DATA_WIDTH-1:0] r_data_i;
  resp_t                 r_resp_i;
  logic                  r_last_i;

  modport master (
    output aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o,
    input  aw_ready_i,
    output w_valid_o, w_data_o, w_strb_o, w_last_o,
    input  w_ready_i,
    input  b_valid_i, b_resp_i,
    output b_ready_o,
    output ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o,
    input  ar_ready_i,
    input  r_valid_i, r_data_i, r_resp_i, r_last_i,
    output r_ready_o
  );

  modport slave (
    input  aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o,
    output aw_ready_i,
    input  w_valid_o, w_data_o, w_strb_o, w_last_o,
    output w_ready_i,
    output b_valid_i, b_resp_i,
    input  b_ready_o,
    input  ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o,
    output ar_ready_i,
    output r_valid_i, r_data_i, r_resp_i, r_last_i,
    input  r_ready_o
  );

endinterface

// File: rtl/axi_wr_rd_checker.sv
// AXI4 traffic stage: writes NUM_TXN words, reads each back and counts mismatches/bad responses.
// Optional watchdog enabled with `define AXI_CHK_TIMEOUT_EN.
module axi_wr_rd_checker
  import axi_chk_pkg::*;
#(
  parameter int unsigned                AXI_ID_WIDTH   = 5,
  parameter int unsigned                AXI_ADDR_WIDTH = 64,
  parameter int unsigned                AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = 64'h8000_0000,
  parameter int unsigned                NUM_TXN        = 16,
  parameter logic [AXI_DATA_WIDTH-1:0]  DATA_SEED      = 64'h0123_4567_89AB_CDEF,
  parameter logic [AXI_ID_WIDTH-1:0]    TXN_ID         = '0,
  parameter int unsigned                TIMEOUT        = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  axi_wr_rd_checker_if.master  bus,
  output logic                 done_o,
  output logic [15:0]          err_cnt_o,
  output logic                 timeout_o
);

  localparam int unsigned      IDX_W    = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);

  // Pattern for word i: seed xor the low byte of i replicated, plus i.
  function automatic logic [63:0] exp_data(input logic [IDX_W-1:0] idx);
    logic [7:0] idx_b;
    idx_b = 8'(idx);
    return (DATA_SEED ^ {8{idx_b}}) + 64'(idx);
  endfunction

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      start_q, start_d;
  logic                      done_q, done_d;
  logic [15:0]               err_cnt_q, err_cnt_d;
  logic                      err_inc;
  logic                      start_rise;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [63:0]               data;

  assign start_rise = start_i & ~start_q;
  assign addr       = BASE_ADDR + (AXI_ADDR_WIDTH'(idx_q) << 3);
  assign data       = exp_data(idx_q);
  assign start_d    = start_i;

`ifdef AXI_CHK_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic             waiting;
  assign waiting = (state_q == ST_WR) || (state_q == ST_WB) ||
                   (state_q == ST_RD) || (state_q == ST_RR);
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    err_inc    = 1'b0;
`ifdef AXI_CHK_TIMEOUT_EN
    timeout_d  = timeout_q;
    timer_d    = timer_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          err_cnt_d  = '0;
          done_d     = 1'b0;
          idx_d      = '0;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = ST_WR;
`ifdef AXI_CHK_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
        end
      end
      ST_WR: begin
        // Each channel retires on its own handshake; both may finish in one cycle.
        aw_valid_d = aw_valid_q & ~bus.aw_ready_i;
        w_valid_d  = w_valid_q & ~bus.w_ready_i;
        if (!aw_valid_d && !w_valid_d) state_d = ST_WB;
      end
      ST_WB: begin
        if (bus.b_valid_i) begin
          err_inc = (bus.b_resp_i != RESP_OKAY);
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (bus.ar_ready_i) state_d = ST_RR;
      end
      ST_RR: begin
        if (bus.r_valid_i) begin
          err_inc = (bus.r_data_i != data) || (bus.r_resp_i != RESP_OKAY) || !bus.r_last_i;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d      = idx_q + 1'b1;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = ST_WR;
        end
      end
      ST_DONE: begin
        if (!start_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AXI_CHK_TIMEOUT_EN
    if (waiting && timer_q == TMR_W'(TIMEOUT - 1)) begin
      timeout_d  = 1'b1;
      done_d     = 1'b1;
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      err_inc    = 1'b0;
      state_d    = ST_DONE;
    end
    if (state_d != state_q) timer_d = '0;
    else if (waiting)       timer_d = timer_q + 1'b1;
`endif

    if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

`ifdef AXI_CHK_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign bus.aw_valid_o = aw_valid_q;
  assign bus.aw_addr_o  = addr;
  assign bus.aw_id_o    = TXN_ID;
  assign bus.aw_len_o   = LEN_SINGLE;
  assign bus.aw_size_o  = SIZE_8B;
  assign bus.aw_burst_o = BURST_INCR;

  assign bus.w_valid_o  = w_valid_q;
  assign bus.w_data_o   = data;
  assign bus.w_strb_o   = 8'hFF;
  assign bus.w_last_o   = 1'b1;

  assign bus.b_ready_o  = (state_q == ST_WB);

  assign bus.ar_valid_o = (state_q == ST_RD);
  assign bus.ar_addr_o  = addr;
  assign bus.ar_id_o    = TXN_ID;
  assign bus.ar_len_o   = LEN_SINGLE;
  assign bus.ar_size_o  = SIZE_8B;
  assign bus.ar_burst_o = BURST_INCR;

  assign bus.r_ready_o  = (state_q == ST_RR);

  assign done_o    = done_q;
  assign err_cnt_o = err_cnt_q;

endmodule
